// File: rtl/pixel_word_fetcher.sv
// Framebuffer word fetcher feeding the pixel serializer.
// Streams words through a single-outstanding req/ack port into a small FIFO.
module pixel_word_fetcher #(
    parameter int WORD_WIDTH = 16,
    parameter int H_WORDS    = 40,
    parameter int V_LINES    = 480,
    parameter int ADDR_WIDTH = 16,
    parameter int FB_BASE    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  word_take,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic                  underflow,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_data
);

    localparam int TOTAL = H_WORDS * V_LINES;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(FB_BASE);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] buf_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;
    logic [PW:0]           count_nx;
    logic [CW-1:0]         wcnt;
    logic                  push;
    logic                  pop;
    logic                  room_nx;

    // an ack coinciding with frame_start belongs to the abandoned frame
    assign push       = mem_req & mem_ack & ~frame_start;
    assign pop        = word_take & word_valid;
    assign word_valid = (count != '0);
    assign word_out   = word_valid ? buf_q[rd_ptr] : '0;
    assign room_nx    = (count_nx < DEPTH);

    always_comb begin
        count_nx = count;
        unique case ({push, pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            buf_q[wr_ptr] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= BASE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
            wcnt      <= '0;
        end else if (frame_start) begin
            state     <= FETCH;
            mem_req   <= 1'b0;
            mem_addr  <= BASE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
            wcnt      <= '0;
        end else begin
            count <= count_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (word_take && !word_valid)
                underflow <= 1'b1;
            unique case (state)
                IDLE: mem_req <= 1'b0;
                FETCH: begin
                    if (push) begin
                        mem_addr <= mem_addr + 1'b1;
                        wcnt     <= wcnt + 1'b1;
                        if (wcnt == CW'(TOTAL - 1)) begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                        end else begin
                            mem_req <= room_nx;
                        end
                    end else if (!mem_req) begin
                        mem_req <= room_nx;
                    end
                end
                DONE: mem_req <= 1'b0;
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_word_fetcher.md
Name: pixel_word_fetcher

Overview:
- Upstream feeder for the pixel serializer (the shift register that loads an N-bit word every N cycles and shifts it out LSB-first).
- Streams framebuffer words from memory in address order through a single-outstanding req/ack read port.
- Buffers the words in a small FIFO and presents the head word so it is stable whenever the serializer loads.
- Flags underflow when the serializer takes a word that is not there.

Parameters:
- WORD_WIDTH, 16, bits per framebuffer word; equals the serializer's N.
- H_WORDS, 40, words per active line.
- V_LINES, 480, active lines per frame.
- ADDR_WIDTH, 16, memory word-address width.
- FB_BASE, 0, word address of the first word of the frame.
- FIFO_DEPTH, 4, word buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; restarts fetching at FB_BASE.
- word_take  in  1  one-cycle pulse on the cycle the serializer loads word_out.
- word_out  out  WORD_WIDTH  current FIFO head; 0 when empty.
- word_valid  out  1  FIFO non-empty.
- underflow  out  1  sticky; set by word_take while the FIFO is empty.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  ADDR_WIDTH  word address; stable while mem_req is high.
- mem_ack  in  1  request accepted; mem_data is valid in this cycle.
- mem_data  in  WORD_WIDTH  read data.

Behaviour:
- Reset (rst=1 at a posedge, any state):
  - state=IDLE; mem_req=0; mem_addr=FB_BASE.
  - FIFO emptied; word_out=0; word_valid=0; underflow=0.
  - word counter=0.
  - rst has priority over every other input.
- FSM states: IDLE, FETCH, DONE.
- IDLE: mem_req=0; waits for frame_start.
- frame_start, in any state, takes effect at that posedge:
  - FIFO flushed; underflow cleared.
  - mem_addr=FB_BASE; word counter=0; state=FETCH.
  - An in-flight request is abandoned: mem_req is deasserted for that edge, and a mem_ack arriving in the frame_start cycle is discarded (no push, no address advance).
- FETCH:
  - mem_req=1 whenever FIFO count < FIFO_DEPTH; otherwise 0.
  - A request, once raised, stays high with mem_addr stable until mem_ack.
  - On mem_req & mem_ack:
    - mem_data is pushed.
    - mem_addr increments by 1, wrapping modulo 2^ADDR_WIDTH.
    - The counter increments.
    - If the counter reaches H_WORDS*V_LINES, state=DONE, with mem_req=0 from the next cycle.
  - Only one request is ever outstanding, so an ack-push always has room.
- DONE: mem_req=0 until frame_start.
- FIFO:
  - Registered head; word_out/word_valid reflect the state after the last posedge.
  - word_take & word_valid pops the head; the next head appears the following cycle.
  - Push and pop in the same cycle: count unchanged; the pushed word enters behind any remaining entries, or becomes the head if the FIFO held one entry.
  - Pointer wrap modulo FIFO_DEPTH.
  - Count range 0..FIFO_DEPTH.
- Underflow: word_take while word_valid=0 sets underflow=1, leaves the FIFO unchanged, and word_out stays 0. Cleared only by rst or frame_start.
- Latency:
  - The first mem_req is raised the cycle after frame_start.
  - A word acked in cycle t is visible on word_out at t+1 if the FIFO was empty.
- No line or blanking awareness: the FIFO simply fills and stalls requests; pacing comes from word_take.

Test Plan (WORD_WIDTH=8, H_WORDS=4, V_LINES=2, FIFO_DEPTH=4, FB_BASE=0x100):
- Reset then frame_start, memory acking each request 2 cycles after it is raised with data = addr[7:0] -> mem_addr sequence 0x100..0x103 acked; mem_req drops once 4 words are buffered; word_out=0x00, word_valid=1.
- Continue with word_take every 8 cycles -> word_out yields 0x00..0x07 in order; exactly 8 acks occur; state DONE; mem_req=0; underflow stays 0.
- A 9th word_take after the FIFO drains -> underflow=1; word_out=0; the next frame_start clears underflow and restarts at 0x100.
- frame_start while mem_req is high for 0x102 and mem_ack is asserted in the same cycle -> data discarded; FIFO empty; the next request is for 0x100.
- FIFO full (count 4) with simultaneous word_take and a pending ack -> not reachable, because mem_req stays 0 when full. Verify that mem_req is never high at count 4, and that a push coinciding with a pop at count 3 leaves count 3.
- rst asserted mid-FETCH with a request pending -> next cycle: mem_req=0, word_valid=0, state IDLE; no further requests until frame_start.
